// File: rtl/hazard_forward_ctrl.sv
// Pending-write tracker for the post-decode pipeline: operand forwarding selects,
// load-use stalls, branch flushes and the drain-then-enter interrupt sequence.
module hazard_forward_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LATE_STAGE = 1,
  localparam int FW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_ra,
  input  logic [REG_AW-1:0] dec_rb,
  input  logic              dec_ra_rd,
  input  logic              dec_rb_rd,
  input  logic              dec_wr_en,
  input  logic [REG_AW-1:0] dec_wr_addr,
  input  logic              dec_late,
  input  logic              br_taken,
  input  logic              irq,
  input  logic              i_flag,
  output logic [FW-1:0]     fwd_sel_a,
  output logic [FW-1:0]     fwd_sel_b,
  output logic              stall,
  output logic              flush_fetch,
  output logic              flush_dec,
  output logic              int_enter,
  output logic              busy
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ENTER = 2'd2;

  logic [DEPTH-1:0]  stg_v;
  logic [DEPTH-1:0]  stg_we;
  logic [DEPTH-1:0]  stg_late;
  logic [REG_AW-1:0] stg_addr [DEPTH];
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [FW-1:0]     sel_a;
  logic [FW-1:0]     sel_b;
  logic              hz_a;
  logic              hz_b;
  logic              match_a;
  logic              match_b;
  logic              stall_int;
  logic              flush_int;
  logic              issue;
  logic              busy_int;

  // Operand lookup: scan oldest to youngest so the youngest hit is the one that sticks.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    hz_a    = 1'b0;
    hz_b    = 1'b0;
    match_a = 1'b0;
    match_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      match_a = stg_v[k] & stg_we[k] & dec_ra_rd & (stg_addr[k] == dec_ra);
      match_b = stg_v[k] & stg_we[k] & dec_rb_rd & (stg_addr[k] == dec_rb);
      sel_a   = match_a ? FW'(k + 1) : sel_a;
      sel_b   = match_b ? FW'(k + 1) : sel_b;
      hz_a    = match_a ? (stg_late[k] & (k < LATE_STAGE)) : hz_a;
      hz_b    = match_b ? (stg_late[k] & (k < LATE_STAGE)) : hz_b;
    end
  end

  // Stall/flush arbitration and interrupt sequencing; a taken branch overrides any stall.
  always_comb begin
    busy_int  = |stg_v;
    stall_int = ~br_taken & (hz_a | hz_b | (state == ST_DRAIN));
    flush_int = br_taken | (state == ST_ENTER);
    issue     = dec_valid & ~stall_int & ~flush_int & (state == ST_RUN);
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (irq & i_flag & ~br_taken & ~stall_int) state_nxt = ST_DRAIN;
        else                                       state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (!busy_int) state_nxt = ST_ENTER;
        else           state_nxt = ST_DRAIN;
      end
      ST_ENTER: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Outputs read as zero for the whole reset cycle, before the stage registers clear.
  assign fwd_sel_a   = rst ? '0 : sel_a;
  assign fwd_sel_b   = rst ? '0 : sel_b;
  assign stall       = ~rst & stall_int;
  assign flush_fetch = ~rst & flush_int;
  assign flush_dec   = ~rst & flush_int;
  assign int_enter   = ~rst & (state == ST_ENTER);
  assign busy        = ~rst & busy_int;

  // Stage shift register and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      stg_v    <= '0;
      stg_we   <= '0;
      stg_late <= '0;
      for (int k = 0; k < DEPTH; k++) stg_addr[k] <= '0;
    end else begin
      state    <= state_nxt;
      stg_v    <= {stg_v[DEPTH-2:0], issue};
      stg_we   <= {stg_we[DEPTH-2:0], issue & dec_wr_en};
      stg_late <= {stg_late[DEPTH-2:0], issue & dec_late};
      for (int k = DEPTH - 1; k > 0; k--) stg_addr[k] <= stg_addr[k-1];
      stg_addr[0] <= issue ? dec_wr_addr : '0;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: two instances (DEPTH=2/LATE=1 and
// DEPTH=3/LATE=2) share stimulus; a queue-based pipeline model predicts every cycle.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       dec_valid = 1'b0, dec_ra_rd = 1'b0, dec_rb_rd = 1'b0;
  logic       dec_wr_en = 1'b0, dec_late = 1'b0, br_taken = 1'b0;
  logic       irq = 1'b0, i_flag = 1'b0;
  logic [4:0] dec_ra = 5'd0, dec_rb = 5'd0, dec_wr_addr = 5'd0;

  logic [1:0] sa2, sb2, sa3, sb3;
  logic       st2, ff2, fd2, ie2, bz2;
  logic       st3, ff3, fd3, ie3, bz3;

  hazard_forward_ctrl u_d2 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_ra_rd(dec_ra_rd), .dec_rb_rd(dec_rb_rd), .dec_wr_en(dec_wr_en),
    .dec_wr_addr(dec_wr_addr), .dec_late(dec_late), .br_taken(br_taken), .irq(irq),
    .i_flag(i_flag), .fwd_sel_a(sa2), .fwd_sel_b(sb2), .stall(st2), .flush_fetch(ff2),
    .flush_dec(fd2), .int_enter(ie2), .busy(bz2)
  );

  hazard_forward_ctrl #(.REG_AW(5), .DEPTH(3), .LATE_STAGE(2)) u_d3 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_ra_rd(dec_ra_rd), .dec_rb_rd(dec_rb_rd), .dec_wr_en(dec_wr_en),
    .dec_wr_addr(dec_wr_addr), .dec_late(dec_late), .br_taken(br_taken), .irq(irq),
    .i_flag(i_flag), .fwd_sel_a(sa3), .fwd_sel_b(sb3), .stall(st3), .flush_fetch(ff3),
    .flush_dec(fd3), .int_enter(ie3), .busy(bz3)
  );

  typedef struct { bit v; bit we; bit late; int addr; } ent_t;
  typedef struct { int sel_a; int sel_b; bit stall; bit ff; bit fd; bit ie; bit busy; } exp_t;

  localparam int RUN = 0, DRAIN = 1, ENTER = 2;

  ent_t pipe2[$], pipe3[$];
  int   st2m = RUN, st3m = RUN;
  exp_t q2[$], q3[$];
  int   checks = 0, errors = 0;

  // Index of the youngest pending write to register a, or -1.
  function automatic int youngest(input ent_t p[$], input int a, input bit rd);
    if (!rd) return -1;
    for (int k = 0; k < p.size(); k++)
      if (p[k].v && p[k].we && p[k].addr == a) return k;
    return -1;
  endfunction

  function automatic exp_t predict(input ent_t p[$], input int late_st, input int st);
    exp_t e;
    int ka, kb;
    bit la, lb;
    e = '{sel_a: 0, sel_b: 0, stall: 1'b0, ff: 1'b0, fd: 1'b0, ie: 1'b0, busy: 1'b0};
    if (rst) return e;
    ka = youngest(p, int'(dec_ra), dec_ra_rd);
    kb = youngest(p, int'(dec_rb), dec_rb_rd);
    e.sel_a = ka + 1;
    e.sel_b = kb + 1;
    la = (ka >= 0) ? (p[ka].late && ka < late_st) : 1'b0;
    lb = (kb >= 0) ? (p[kb].late && kb < late_st) : 1'b0;
    e.stall = !br_taken && (la || lb || st == DRAIN);
    e.ff    = br_taken || st == ENTER;
    e.fd    = e.ff;
    e.ie    = (st == ENTER);
    foreach (p[k]) if (p[k].v) e.busy = 1'b1;
    return e;
  endfunction

  task automatic advance(ref ent_t p[$], ref int st, input exp_t e);
    ent_t b, n;
    bit issue;
    b = '{v: 1'b0, we: 1'b0, late: 1'b0, addr: 0};
    if (rst) begin
      foreach (p[k]) p[k] = b;
      st = RUN;
      return;
    end
    issue = dec_valid && !e.stall && !e.fd && st == RUN;
    n = b;
    if (issue) begin
      n.v = 1'b1; n.we = dec_wr_en; n.late = dec_late; n.addr = int'(dec_wr_addr);
    end
    void'(p.pop_back());
    p.push_front(n);
    case (st)
      RUN:     if (irq && i_flag && !br_taken && !e.stall) st = DRAIN;
      DRAIN:   if (!e.busy) st = ENTER;
      ENTER:   st = RUN;
      default: st = RUN;
    endcase
  endtask

  task automatic cyc(input bit r, input bit v, input int ra, input bit rar, input int rb,
                     input bit rbr, input bit we, input int wa, input bit lt,
                     input bit br, input bit ir, input bit ifl);
    exp_t e2, e3;
    @(posedge clk);
    #1;
    rst = r; dec_valid = v; dec_ra = 5'(ra); dec_ra_rd = rar; dec_rb = 5'(rb);
    dec_rb_rd = rbr; dec_wr_en = we; dec_wr_addr = 5'(wa); dec_late = lt;
    br_taken = br; irq = ir; i_flag = ifl;
    e2 = predict(pipe2, 1, st2m);
    e3 = predict(pipe3, 2, st3m);
    q2.push_back(e2);
    q3.push_back(e3);
    advance(pipe2, st2m, e2);
    advance(pipe3, st3m, e3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("d2 fwd_sel_a", 32'(sa2), e.sel_a);
      chk("d2 fwd_sel_b", 32'(sb2), e.sel_b);
      chk("d2 stall", 32'(st2), int'(e.stall));
      chk("d2 flush_fetch", 32'(ff2), int'(e.ff));
      chk("d2 flush_dec", 32'(fd2), int'(e.fd));
      chk("d2 int_enter", 32'(ie2), int'(e.ie));
      chk("d2 busy", 32'(bz2), int'(e.busy));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("d3 fwd_sel_a", 32'(sa3), e.sel_a);
      chk("d3 fwd_sel_b", 32'(sb3), e.sel_b);
      chk("d3 stall", 32'(st3), int'(e.stall));
      chk("d3 flush_fetch", 32'(ff3), int'(e.ff));
      chk("d3 flush_dec", 32'(fd3), int'(e.fd));
      chk("d3 int_enter", 32'(ie3), int'(e.ie));
      chk("d3 busy", 32'(bz3), int'(e.busy));
    end
  end

  initial begin
    ent_t b;
    bit irq_l;
    b = '{v: 1'b0, we: 1'b0, late: 1'b0, addr: 0};
    for (int k = 0; k < 2; k++) pipe2.push_back(b);
    for (int k = 0; k < 3; k++) pipe3.push_back(b);

    // reset
    cyc(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ADD r1; ADD r2,r1; reader r1 one slot later; third reader
    cyc(0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 7, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 8, 0, 0, 0, 0);
    idle(3);
    // LD r3; OR r4,r3 held in decode while stalled
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0);
    idle(3);
    // r5 written twice, reader on operand B, then with B not read
    cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // branch while a load-use stall is pending
    cyc(0, 1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
    cyc(0, 1, 6, 1, 0, 0, 1, 9, 0, 1, 0, 0);
    idle(4);
    // irq masked, then taken with the pipeline full
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 1, 10 + i, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0, 1, 12, 0, 0, 1, 1);
    idle(2);
    // reset in the middle of a drain
    cyc(0, 1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 14, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 15, 1, 16, 1, 1, 16, 0, 0, 0, 0);

    // randomized traffic over a small register window to provoke hazards
    irq_l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) irq_l = !irq_l;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          irq_l, $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(q2.size() + q3.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
